// File: rtl/hamming_tx_scheduler_pkg.sv
// hamming_pkg: shared definitions for the Hamming transmit scheduler.
//   - MSG_W / CW_W: message and codeword widths (16 -> 21 bits)
//   - P*_POS / P*_MASK: parity bit positions and the codeword bits each covers
//   - state_t: scheduler FSM states
//   - rr_pick(): round-robin search over up to RR_MAX requesters
package hamming_pkg;

  localparam int MSG_W = 16;
  localparam int CW_W  = 21;

  // Parity positions (0-based) inside the codeword
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 3;
  localparam int P3_POS = 7;
  localparam int P4_POS = 15;

  // Coverage masks: parity k covers bit i when bit k of (i+1) is set
  localparam logic [CW_W-1:0] P0_MASK = 21'h155555;
  localparam logic [CW_W-1:0] P1_MASK = 21'h066666;
  localparam logic [CW_W-1:0] P2_MASK = 21'h187878;
  localparam logic [CW_W-1:0] P3_MASK = 21'h007F80;
  localparam logic [CW_W-1:0] P4_MASK = 21'h1F8000;

  // Index of the final serial bit of a frame
  localparam logic [4:0] LAST_BIT = 5'(CW_W - 1);

  localparam int RR_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    SHIFT
  } state_t;

  // Returns {found, index}: first asserted valid bit at or above ptr,
  // wrapping modulo nreq. ptr must be below nreq.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input logic [3:0]        nreq);
    logic [3:0] res;
    logic [3:0] sum;
    logic [3:0] idx;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = (sum >= nreq) ? sum - nreq : sum;
      if ((4'(k) < nreq) && !res[3] && !idx[3] && valid[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_tx_scheduler_if.sv
// hamming_tx_scheduler_if: requester bus plus serial channel of the scheduler.
//   master: message producers / channel model (drives req_valid, req_data, tx_en)
//   slave : the scheduler (drives req_ready, tx_bit, tx_frame, tx_last,
//           cw_out, cw_id, busy)
interface hamming_tx_scheduler_if import hamming_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*MSG_W-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  tx_en;
  logic                  tx_bit;
  logic                  tx_frame;
  logic                  tx_last;
  logic [CW_W-1:0]       cw_out;
  logic [IDW-1:0]        cw_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, tx_en,
    input  req_ready, tx_bit, tx_frame, tx_last, cw_out, cw_id, busy
  );

  modport slave (
    input  req_valid, req_data, tx_en,
    output req_ready, tx_bit, tx_frame, tx_last, cw_out, cw_id, busy
  );

endinterface

// File: rtl/hamming_tx_scheduler_mux_hamming.sv
// mux_hamming: combinational Hamming(21,16) encoder with even parity.
//   m : 16-bit message
//   e : 21-bit codeword, parity at 0,1,3,7,15, data bits fill the rest
//       in ascending order (m0 at e[2], m15 at e[20])
module mux_hamming import hamming_pkg::*; (
  input  logic [MSG_W-1:0] m,
  output logic [CW_W-1:0]  e
);

  logic [CW_W-1:0] d;

  // Scatter the message into the non-parity positions, parity slots left zero
  always_comb begin
    d        = '0;
    d[2]     = m[0];
    d[6:4]   = m[3:1];
    d[14:8]  = m[10:4];
    d[20:16] = m[15:11];
  end

  // Each parity bit is the XOR of the data bits it covers
  always_comb begin
    e         = d;
    e[P0_POS] = ^(d & P0_MASK);
    e[P1_POS] = ^(d & P1_MASK);
    e[P2_POS] = ^(d & P2_MASK);
    e[P3_POS] = ^(d & P3_MASK);
    e[P4_POS] = ^(d & P4_MASK);
  end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// hamming_tx_scheduler: round-robin arbiter feeding one shared Hamming
// encoder, followed by an LSB-first serializer with channel back-pressure.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of hamming_tx_scheduler_if
//              req_valid/req_data/req_ready - per-requester message handshake
//              tx_en  - channel accepts the current bit
//              tx_bit/tx_frame/tx_last - serial output and framing
//              cw_out/cw_id - codeword in flight and its requester
//              busy   - scheduler not idle
module hamming_tx_scheduler import hamming_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_tx_scheduler_if.slave  bus
);

  state_t            state, state_nxt;
  logic [IDW-1:0]    ptr;
  logic [3:0]        pick;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic              xfer;
  logic [MSG_W-1:0]  msg_q;
  logic [CW_W-1:0]   codeword;
  logic [CW_W-1:0]   sreg;
  logic [CW_W-1:0]   cw_q;
  logic [IDW-1:0]    id_q;
  logic [4:0]        cnt;

  mux_hamming u_enc (
    .m (msg_q),
    .e (codeword)
  );

  // Round-robin search starting at ptr; requests are re-evaluated every
  // cycle, so nothing is latched until the actual transfer
  always_comb begin
    pick        = rr_pick(8'(bus.req_valid), 3'(ptr), 4'(NREQ));
    grant_found = pick[3];
    grant_idx   = IDW'(pick[2:0]);
  end

  // One-hot grant, only offered while idle
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = |(bus.req_valid & bus.req_ready);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and frame outputs; everything holds while tx_en is low
  always_comb begin
    state_nxt    = state;
    bus.tx_frame = 1'b0;
    bus.tx_bit   = 1'b0;
    bus.tx_last  = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (xfer) state_nxt = ENC;
      end
      ENC: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.tx_frame = 1'b1;
        bus.tx_bit   = sreg[0];
        bus.tx_last  = (cnt == LAST_BIT);
        if (bus.tx_en && cnt == LAST_BIT) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on transfer, load encoder result in ENC, shift in SHIFT.
  // cnt is cleared when the frame ends so it never passes LAST_BIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      msg_q <= '0;
      sreg  <= '0;
      cw_q  <= '0;
      id_q  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            msg_q <= bus.req_data[int'(grant_idx)*MSG_W +: MSG_W];
            id_q  <= grant_idx;
            ptr   <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
          end
        end
        ENC: begin
          sreg <= codeword;
          cw_q <= codeword;
          cnt  <= '0;
        end
        SHIFT: begin
          if (bus.tx_en) begin
            sreg <= sreg >> 1;
            cnt  <= (cnt == LAST_BIT) ? 5'd0 : cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cw_out = cw_q;
  assign bus.cw_id  = id_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// tb_hamming_tx_scheduler: scenario tasks driving the scheduler and checking
// its serial frames against a position-rule Hamming model and a round-robin
// pointer model kept in the bench.
module tb_hamming_tx_scheduler;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   model_ptr = 0;

  hamming_tx_scheduler_if #(.NREQ(NREQ)) bus ();

  hamming_tx_scheduler #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and a cycle counter for frame spacing
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference encoder: data fills non-power-of-two 1-based positions in order,
  // parity at position 2^k is the even parity of positions with bit k set
  function automatic logic [20:0] ref_encode(input logic [15:0] m);
    logic [20:0] e;
    int k;
    e = '0;
    k = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        e[pos-1] = m[k];
        k++;
      end
    end
    for (int p = 0; p < 5; p++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= 21; pos++)
        if ((pos & (1 << p)) != 0) par ^= e[pos-1];
      e[(1 << p) - 1] = par;
    end
    return e;
  endfunction

  // Reference arbiter: first valid requester from p upward with wrap
  function automatic int ref_grant(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++)
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    return (g < 0) ? '0 : NREQ'(1 << g);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.tx_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic set_req(input int r, input logic [15:0] d);
    bus.req_data[r*16 +: 16] = d;
    bus.req_valid[r] = 1'b1;
  endtask

  // Observes one frame (no checking); optionally stalls tx_en at two bit indices
  task automatic collect_frame(input int stall_a, input int stall_b, input int stall_len,
                               output logic [20:0] bits, output int nbits, output int cycles,
                               output logic [20:0] cw, output int id, output int last_pos,
                               output int nlast, output bit hold_ok, output int start_cyc,
                               output bit timeout);
    int guard;
    int idx;
    bit sa, sb;
    logic b0, l0;
    bits = '0; nbits = 0; cycles = 0; cw = '0; id = -1; last_pos = -1;
    nlast = 0; hold_ok = 1'b1; start_cyc = 0; timeout = 1'b0;
    sa = 1'b0; sb = 1'b0; idx = 0;
    bus.tx_en = 1'b1;
    guard = 0;
    while (bus.tx_frame !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (bus.tx_frame !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    start_cyc = cyc;
    cw = bus.cw_out;
    id = int'(bus.cw_id);
    while (bus.tx_frame === 1'b1 && cycles < 100) begin
      if ((idx == stall_a && !sa) || (idx == stall_b && !sb)) begin
        if (idx == stall_a) sa = 1'b1; else sb = 1'b1;
        b0 = bus.tx_bit;
        l0 = bus.tx_last;
        bus.tx_en = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          cycles++;
          @(negedge clk);
          if (bus.tx_bit !== b0 || bus.tx_last !== l0 || bus.tx_frame !== 1'b1) hold_ok = 1'b0;
        end
        bus.tx_en = 1'b1;
      end
      if (bus.cw_out !== cw) hold_ok = 1'b0;
      cycles++;
      if (idx < 21) bits[idx] = bus.tx_bit;
      if (bus.tx_last === 1'b1) begin
        nlast++;
        last_pos = idx;
      end
      idx++;
      @(negedge clk);
    end
    nbits = idx;
    if (cycles >= 100) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.tx_en = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.tx_frame, bus.tx_bit, bus.tx_last} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000", {bus.busy, bus.tx_frame, bus.tx_bit, bus.tx_last});
    end
    n_checks++;
    if (bus.cw_out !== 21'h0 || bus.cw_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: got cw=%h id=%0d ready=%b, expected 0/0/0000", bus.cw_out, bus.cw_id, bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    bus.req_valid = 4'b1010;
    #1;
    n_checks++;
    if (bus.req_ready !== onehot(ref_grant(4'b1010, model_ptr))) begin
      n_fail++;
      $display("[TB] FAIL reset_ptr: got ready=%b, expected %b", bus.req_ready, onehot(ref_grant(4'b1010, model_ptr)));
    end
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    logic [20:0] bits, cw;
    int nbits, cycles, id, last_pos, nlast, st, g;
    bit hold_ok, to;
    @(negedge clk);
    bus.tx_en = 1'b1;
    set_req(0, 16'h0001);
    #1;
    g = ref_grant(bus.req_valid, model_ptr);
    n_checks++;
    if (bus.req_ready !== onehot(g)) begin
      n_fail++;
      $display("[TB] FAIL single_grant: got %b, expected %b", bus.req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.tx_frame !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_enc: got busy=%b frame=%b, expected 1/0", bus.busy, bus.tx_frame);
    end
    @(negedge clk);
    n_checks++;
    if (bus.tx_frame !== 1'b1 || bus.cw_out !== ref_encode(16'h0001)) begin
      n_fail++;
      $display("[TB] FAIL single_latency: got frame=%b cw=%h, expected 1/%h", bus.tx_frame, bus.cw_out, ref_encode(16'h0001));
    end
    collect_frame(-1, -1, 0, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
    n_checks++;
    if (to !== 1'b0 || bits !== ref_encode(16'h0001) || nbits !== 21 || id !== g) begin
      n_fail++;
      $display("[TB] FAIL single_frame: got to=%b bits=%h n=%0d id=%0d, expected 0/%h/21/%0d", to, bits, nbits, id, ref_encode(16'h0001), g);
    end
    n_checks++;
    if (last_pos !== 20 || nlast !== 1 || hold_ok !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_last: got last=%0d nlast=%0d hold=%b busy=%b, expected 20/1/1/0", last_pos, nlast, hold_ok, bus.busy);
    end
  endtask

  task automatic test_all_ones();
    logic [20:0] bits, cw;
    int nbits, cycles, id, last_pos, nlast, st, g;
    bit hold_ok, to;
    @(negedge clk);
    set_req(2, 16'hFFFF);
    #1;
    g = ref_grant(bus.req_valid, model_ptr);
    n_checks++;
    if (bus.req_ready !== onehot(g)) begin
      n_fail++;
      $display("[TB] FAIL ones_grant: got %b, expected %b", bus.req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    collect_frame(-1, -1, 0, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
    n_checks++;
    if (to !== 1'b0 || cw !== ref_encode(16'hFFFF) || bits !== ref_encode(16'hFFFF) || id !== g || cycles !== 21) begin
      n_fail++;
      $display("[TB] FAIL ones_frame: got to=%b cw=%h bits=%h id=%0d cyc=%0d, expected 0/%h/%h/%0d/21", to, cw, bits, id, cycles, ref_encode(16'hFFFF), ref_encode(16'hFFFF), g);
    end
    bus.req_valid = 4'b1001;
    #1;
    n_checks++;
    if (bus.req_ready !== onehot(ref_grant(4'b1001, model_ptr))) begin
      n_fail++;
      $display("[TB] FAIL ones_ptr: got %b, expected %b", bus.req_ready, onehot(ref_grant(4'b1001, model_ptr)));
    end
    bus.req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [20:0] bits, cw;
    logic [15:0] d [NREQ];
    int nbits, cycles, id, last_pos, nlast, st, prev_st, g;
    bit hold_ok, to;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      d[i] = {4'(i), 12'($urandom)};
      set_req(i, d[i]);
    end
    prev_st = 0;
    for (int f = 0; f < 5; f++) begin
      #1;
      g = ref_grant(bus.req_valid, model_ptr);
      n_checks++;
      if (bus.req_ready !== onehot(g)) begin
        n_fail++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, expected %b", f, bus.req_ready, onehot(g));
      end
      model_ptr = (g + 1) % NREQ;
      collect_frame(-1, -1, 0, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
      n_checks++;
      if (to !== 1'b0 || id !== g || cw !== ref_encode(d[g]) || bits !== ref_encode(d[g]) || nbits !== 21) begin
        n_fail++;
        $display("[TB] FAIL rr_frame[%0d]: got to=%b id=%0d cw=%h bits=%h n=%0d, expected 0/%0d/%h/%h/21", f, to, id, cw, bits, nbits, g, ref_encode(d[g]), ref_encode(d[g]));
      end
      if (f > 0) begin
        n_checks++;
        if (st - prev_st !== 23) begin
          n_fail++;
          $display("[TB] FAIL rr_spacing[%0d]: got %0d cycles, expected 23", f, st - prev_st);
        end
      end
      prev_st = st;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_stall();
    logic [20:0] bits, cw;
    logic [15:0] dat;
    int nbits, cycles, id, last_pos, nlast, st, g, r;
    bit hold_ok, to;
    @(negedge clk);
    r = $urandom_range(0, NREQ - 1);
    dat = 16'($urandom);
    set_req(r, dat);
    #1;
    g = ref_grant(bus.req_valid, model_ptr);
    n_checks++;
    if (bus.req_ready !== onehot(g)) begin
      n_fail++;
      $display("[TB] FAIL stall_grant: got %b, expected %b", bus.req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    collect_frame(7, 20, 5, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
    n_checks++;
    if (to !== 1'b0 || bits !== ref_encode(dat) || nbits !== 21 || cycles !== 31) begin
      n_fail++;
      $display("[TB] FAIL stall_frame: got to=%b bits=%h n=%0d cyc=%0d, expected 0/%h/21/31", to, bits, nbits, cycles, ref_encode(dat));
    end
    n_checks++;
    if (hold_ok !== 1'b1 || last_pos !== 20 || nlast !== 1 || id !== g) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: got hold=%b last=%0d nlast=%0d id=%0d, expected 1/20/1/%0d", hold_ok, last_pos, nlast, id, g);
    end
  endtask

  task automatic test_reset_abort();
    logic [20:0] bits, cw;
    int nbits, cycles, id, last_pos, nlast, st, g, guard;
    bit hold_ok, to;
    @(negedge clk);
    bus.tx_en = 1'b1;
    set_req(1, 16'h1234);
    #1;
    g = ref_grant(bus.req_valid, model_ptr);
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    set_req(3, 16'hBEEF);
    guard = 0;
    while (bus.tx_frame !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.tx_frame !== 1'b1 || bus.cw_out !== ref_encode(16'h1234)) begin
      n_fail++;
      $display("[TB] FAIL abort_midframe: got frame=%b cw=%h, expected 1/%h", bus.tx_frame, bus.cw_out, ref_encode(16'h1234));
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.tx_frame, bus.busy, bus.tx_bit, bus.tx_last} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL abort_async: got %b, expected 0000", {bus.tx_frame, bus.busy, bus.tx_bit, bus.tx_last});
    end
    model_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    g = ref_grant(bus.req_valid, model_ptr);
    n_checks++;
    if (bus.req_ready !== onehot(g)) begin
      n_fail++;
      $display("[TB] FAIL abort_ptr: got %b, expected %b", bus.req_ready, onehot(g));
    end
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    collect_frame(-1, -1, 0, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
    n_checks++;
    if (to !== 1'b0 || id !== g || bits !== ref_encode(16'h1234) || nbits !== 21) begin
      n_fail++;
      $display("[TB] FAIL abort_restart: got to=%b id=%0d bits=%h n=%0d, expected 0/%0d/%h/21", to, id, bits, nbits, g, ref_encode(16'h1234));
    end
  endtask

  task automatic test_zero_msg();
    logic [20:0] bits, cw;
    int nbits, cycles, id, last_pos, nlast, st, g;
    bit hold_ok, to;
    @(negedge clk);
    bus.req_data[3*16 +: 16] = 16'hA5A5;
    set_req(1, 16'h0000);
    #1;
    g = ref_grant(bus.req_valid, model_ptr);
    model_ptr = (g + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    collect_frame(-1, -1, 0, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
    n_checks++;
    if (to !== 1'b0 || cw !== 21'h0 || bits !== 21'h0 || cycles !== 21 || id !== 1) begin
      n_fail++;
      $display("[TB] FAIL zero_frame: got to=%b cw=%h bits=%h cyc=%0d id=%0d, expected 0/0/0/21/1", to, cw, bits, cycles, id);
    end
  endtask

  task automatic test_random();
    logic [20:0] bits, cw;
    logic [15:0] d [NREQ];
    logic [NREQ-1:0] mask;
    int nbits, cycles, id, last_pos, nlast, st, g, sa, sl;
    bit hold_ok, to;
    @(negedge clk);
    for (int round = 0; round < 8; round++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        d[i] = 16'($urandom);
        bus.req_data[i*16 +: 16] = d[i];
      end
      bus.req_valid = mask;
      sa = $urandom_range(0, 20);
      sl = $urandom_range(0, 3);
      #1;
      g = ref_grant(mask, model_ptr);
      n_checks++;
      if (bus.req_ready !== onehot(g)) begin
        n_fail++;
        $display("[TB] FAIL rand_grant[%0d]: got %b, expected %b", round, bus.req_ready, onehot(g));
      end
      model_ptr = (g + 1) % NREQ;
      @(negedge clk);
      bus.req_valid = '0;
      collect_frame(sa, -1, sl, bits, nbits, cycles, cw, id, last_pos, nlast, hold_ok, st, to);
      n_checks++;
      if (to !== 1'b0 || id !== g || bits !== ref_encode(d[g]) || cycles !== 21 + sl || hold_ok !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rand_frame[%0d]: got to=%b id=%0d bits=%h cyc=%0d hold=%b, expected 0/%0d/%h/%0d/1", round, to, id, bits, cycles, hold_ok, g, ref_encode(d[g]), 21 + sl);
      end
    end
  endtask

  // Scenario sequence
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_en     = 1'b0;
    test_reset();
    test_single();
    test_all_ones();
    test_round_robin();
    test_stall();
    test_reset_abort();
    test_zero_msg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the scheduler wedges somewhere unbounded
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
